// File: rtl/mips_sequencer.sv
// Multi-cycle MIPS_32 control sequencer: owns PC and IR, steps each
// instruction FETCH..WRITEBACK and drives registered datapath strobes.
module mips_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] instr,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic [31:0] rs_data,
  input  logic        alu_zero,
  output logic [7:0]  pc,
  output logic [31:0] ir,
  output logic [7:0]  link_pc,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic        retire
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    K_R, K_JR, K_J, K_JAL, K_BEQ,
    K_BNE, K_ADDI, K_LW, K_SW, K_BAD
  } kind_t;

  function automatic kind_t classify(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    kind_t k;
    unique case (op)
      6'h00:   k = (fn == 6'h08) ? K_JR : K_R;
      6'h02:   k = K_J;
      6'h03:   k = K_JAL;
      6'h04:   k = K_BEQ;
      6'h05:   k = K_BNE;
      6'h08:   k = K_ADDI;
      6'h23:   k = K_LW;
      6'h2B:   k = K_SW;
      default: k = K_BAD;
    endcase
    return k;
  endfunction

  state_t      state;
  state_t      ns;
  kind_t       kind;
  kind_t       nkind;
  logic [31:0] nir;
  logic [7:0]  npc;
  logic [7:0]  pc_inc;
  logic        pc_wr;
  logic        taken;
  logic        src_d;
  logic [1:0]  aop_d;
  logic [1:0]  dst_d;
  logic        unused_rs;

  assign unused_rs = ^rs_data[31:8];
  assign kind      = classify(ir[31:26], ir[5:0]);
  assign nkind     = classify(nir[31:26], nir[5:0]);
  assign pc_inc    = pc + 8'd1;
  assign taken     = (kind == K_BEQ) ? alu_zero : !alu_zero;

  always_comb begin
    ns    = state;
    nir   = ir;
    npc   = pc;
    pc_wr = 1'b0;
    unique case (state)
      FETCH: begin
        if (imem_ready) begin
          nir = instr;
          ns  = DECODE;
        end
      end
      DECODE: begin
        unique case (1'b1)
          kind == K_JR: begin
            npc   = rs_data[7:0];
            pc_wr = 1'b1;
            ns    = FETCH;
          end
          kind == K_J: begin
            npc   = ir[7:0];
            pc_wr = 1'b1;
            ns    = FETCH;
          end
          kind == K_JAL: ns = WRITEBACK;
          kind == K_BAD: begin
            npc   = pc_inc;
            pc_wr = 1'b1;
            ns    = FETCH;
          end
          default: ns = EXECUTE;
        endcase
      end
      EXECUTE: begin
        unique case (1'b1)
          kind == K_BEQ || kind == K_BNE: begin
            npc   = taken ? pc_inc + ir[7:0] : pc_inc;
            pc_wr = 1'b1;
            ns    = FETCH;
          end
          kind == K_LW || kind == K_SW: ns = MEM;
          default: ns = WRITEBACK;
        endcase
      end
      MEM: begin
        if (dmem_ready) begin
          if (kind == K_SW) begin
            npc   = pc_inc;
            pc_wr = 1'b1;
            ns    = FETCH;
          end else begin
            ns = WRITEBACK;
          end
        end
      end
      WRITEBACK: begin
        npc   = (kind == K_JAL) ? ir[7:0] : pc_inc;
        pc_wr = 1'b1;
        ns    = FETCH;
      end
      default: ns = FETCH;
    endcase
  end

  // Datapath selects follow the instruction that will be in ir next cycle
  always_comb begin
    src_d = 1'b0;
    aop_d = 2'b00;
    dst_d = 2'b00;
    unique case (nkind)
      K_R:                  begin aop_d = 2'b10; dst_d = 2'b01; end
      K_BEQ, K_BNE:         aop_d = 2'b01;
      K_JAL:                dst_d = 2'b10;
      K_ADDI, K_LW, K_SW:   src_d = 1'b1;
      default:              src_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= 8'h00;
      ir         <= 32'h0;
      link_pc    <= 8'h00;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      reg_write  <= 1'b0;
      illegal    <= 1'b0;
      retire     <= 1'b0;
      alu_src    <= 1'b0;
      alu_op     <= 2'b00;
      reg_dst    <= 2'b00;
      mem_to_reg <= 1'b0;
    end else begin
      state      <= ns;
      ir         <= nir;
      pc         <= npc;
      link_pc    <= npc + 8'd1;
      imem_req   <= (ns == FETCH);
      dmem_req   <= (ns == MEM);
      dmem_we    <= (ns == MEM) && (nkind == K_SW);
      reg_write  <= (ns == WRITEBACK);
      illegal    <= (ns == DECODE) && (nkind == K_BAD);
      retire     <= pc_wr;
      alu_src    <= src_d;
      alu_op     <= aop_d;
      reg_dst    <= dst_d;
      mem_to_reg <= (nkind == K_LW);
    end
  end

endmodule
